masked_affine_skid: RTL and testbench

- Two-entry valid/ready pipeline stage that carries a d-share masked bus between masked S-box / linear-layer stages.
- Applies the affine constant of the linear layer as an XOR onto share 0 only. An all-ones constant complements the unmasked value.
- Breaks combinational ready/valid paths between stages.
- No logic ever combines two shares.

---
 rtl/masked_affine_skid_pkg.sv | 9 +
 rtl/masked_share_reg.sv | 17 +
 rtl/masked_affine_skid.sv | 73 +++++++
 tb/tb_masked_affine_skid.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/masked_affine_skid_pkg.sv
// masked_affine_skid_pkg: stage occupancy state encoding and default share width
package masked_affine_skid_pkg;
  localparam int SHARE_W = 8;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/masked_share_reg.sv
// masked_share_reg: one share's W-bit load-enabled register, kept as its own hierarchy so
// synthesis cannot merge logic across shares.
// Ports: clk, rst_n (async active-low, clears to 0), en_i load enable, d_i next value, q_o stored value.
(* keep_hierarchy = "yes", dont_touch = "yes" *)
module masked_share_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/masked_affine_skid.sv
// masked_affine_skid: two-entry valid/ready skid stage for a D-share masked bus that XORs the
// affine constant onto share 0 at capture.
// Ports: clk, rst_n (async active-low), flush (sync drop of held entries),
// in_valid/in_ready/in_shares/in_cmpl upstream, out_valid/out_ready/out_shares downstream,
// occupancy = held entry count (0..2).
module masked_affine_skid
  import masked_affine_skid_pkg::*;
#(
  parameter int D = 2,
  parameter int W = SHARE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D*W-1:0] in_shares,
  input  logic [W-1:0]   in_cmpl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*W-1:0] out_shares,
  output logic [1:0]     occupancy
);
  state_e state_q, state_d;
  logic in_fire, out_fire, load_main, load_skid, main_from_skid;
  logic [D*W-1:0] skid_q;
  assign in_ready = (state_q != ST_FULL) & ~flush;
  assign out_valid = state_q != ST_EMPTY;
  assign occupancy = state_q;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // The main/skid mux select depends on state only, never on share data.
  assign main_from_skid = state_q == ST_FULL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_EMPTY;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_fire) begin
        state_d = ST_ONE;
        load_main = 1'b1;
      end
      ST_ONE: begin
        if (in_fire & ~out_fire) begin
          state_d = ST_FULL;
          load_skid = 1'b1;
        end else if (in_fire) load_main = 1'b1;
        else if (out_fire) state_d = ST_EMPTY;
      end
      ST_FULL: if (out_fire) begin
        state_d = ST_ONE;
        load_main = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end
  for (genvar i = 0; i < D; i++) begin : g_share
    logic [W-1:0] cap_d, main_d;
    // Only share 0 sees the affine constant; every other share passes through untouched.
    assign cap_d = in_shares[i*W +: W] ^ (i == 0 ? in_cmpl : '0);
    assign main_d = main_from_skid ? skid_q[i*W +: W] : cap_d;
    masked_share_reg #(.W(W)) u_main (
      .clk(clk), .rst_n(rst_n), .en_i(load_main), .d_i(main_d), .q_o(out_shares[i*W +: W])
    );
    masked_share_reg #(.W(W)) u_skid (
      .clk(clk), .rst_n(rst_n), .en_i(load_skid), .d_i(cap_d), .q_o(skid_q[i*W +: W])
    );
  end
endmodule

// File: tb/tb_masked_affine_skid.sv
// tb_masked_affine_skid: directed tests on a d=2/W=8 stage against a FIFO model, plus a random
// recombination scoreboard on a d=3/W=4 stage.
module tb_masked_affine_skid;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_shares = 0;
  logic [7:0] in_cmpl = 0;
  logic in_ready, out_valid;
  logic [15:0] out_shares;
  logic [1:0] occupancy;
  logic r_flush = 0, r_in_valid = 0, r_out_ready = 0;
  logic [11:0] r_in_shares = 0;
  logic [3:0] r_in_cmpl = 0;
  logic r_in_ready, r_out_valid;
  logic [11:0] r_out_shares;
  logic [1:0] r_occupancy;
  int tests = 0, fails = 0;
  logic [15:0] mq[$];
  logic [3:0] rq[$];
  logic [11:0] prev_sh = 0;
  bit prev_stall = 0;
  bit r_acc = 0;
  masked_affine_skid #(.D(2), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares), .in_cmpl(in_cmpl), .out_valid(out_valid), .out_ready(out_ready),
    .out_shares(out_shares), .occupancy(occupancy)
  );
  masked_affine_skid #(.D(3), .W(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_shares(r_in_shares), .in_cmpl(r_in_cmpl), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_shares(r_out_shares), .occupancy(r_occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] recomb(input logic [11:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction
  task automatic drive(input logic v, input logic [15:0] s, input logic [7:0] c, input logic r, input logic f);
    in_valid = v;
    in_shares = s;
    in_cmpl = c;
    out_ready = r;
    flush = f;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Model of the d=2 stage: a FIFO of at most two captured words {share1, share0^cmpl}.
  always @(negedge clk) if (rst_n) begin
    check("occupancy", occupancy, mq.size());
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, mq.size() < 2 && !flush);
    if (mq.size() != 0) check("out_shares", out_shares, mq[0]);
  end
  always @(posedge clk) if (rst_n) begin
    bit ofire, ifire;
    ofire = mq.size() != 0 && out_ready;
    ifire = in_valid && mq.size() < 2 && !flush;
    if (ofire) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (ifire) mq.push_back({in_shares[15:8], in_shares[7:0] ^ in_cmpl});
  end
  always @(negedge rst_n) begin
    mq.delete();
    rq.delete();
  end
  // Random scoreboard for the d=3 stage: recombined outputs must equal recombined inputs ^ cmpl in order.
  always @(negedge clk) if (rst_n) begin
    if (prev_stall) begin
      check("rnd_hold_valid", r_out_valid, 1);
      check("rnd_hold_shares", r_out_shares, prev_sh);
    end
    if (r_out_valid && r_out_ready) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rnd_order: got output %h expected no pending transaction", r_out_shares);
      end else check("rnd_data", recomb(r_out_shares), rq.pop_front());
    end
    if (r_in_valid && r_in_ready) rq.push_back(recomb(r_in_shares) ^ r_in_cmpl);
    prev_stall = r_out_valid && !r_out_ready;
    prev_sh = r_out_shares;
  end
  initial begin
    drive(0, 16'h0, 8'h0, 0, 0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    step;
    drive(1, 16'h3CA5, 8'hFF, 1, 0);
    step;
    drive(0, 16'h0, 8'h0, 1, 0);
    check("single_shares", out_shares, 16'h3C5A);
    check("single_valid", out_valid, 1);
    check("single_recomb", out_shares[15:8] ^ out_shares[7:0], 8'h66);
    step;
    check("single_drain", out_valid, 0);
    drive(1, 16'h1111, 8'h0, 0, 0);
    step;
    drive(1, 16'h2222, 8'h0, 0, 0);
    step;
    drive(1, 16'h3333, 8'h0, 0, 0);
    step;
    check("bp_occupancy", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head", out_shares, 16'h1111);
    step;
    check("bp_stall_head", out_shares, 16'h1111);
    out_ready = 1;
    step;
    check("bp_out1", out_shares, 16'h2222);
    step;
    drive(0, 16'h0, 8'h0, 1, 0);
    check("bp_out2", out_shares, 16'h3333);
    step;
    check("bp_empty", out_valid, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, {8'(i), 8'(i + 100)}, 8'h0, 1, 0);
      step;
      check("tp_occupancy", occupancy, 1);
      check("tp_shares", out_shares, {8'(i), 8'(i + 100)});
    end
    drive(0, 16'h0, 8'h0, 1, 0);
    step;
    drive(1, 16'h0102, 8'h0, 0, 0);
    step;
    drive(1, 16'h0304, 8'h0, 0, 0);
    step;
    check("fl_full", occupancy, 2);
    drive(1, 16'h0506, 8'h0, 0, 1);
    #1;
    check("fl_in_ready", in_ready, 0);
    step;
    drive(0, 16'h0, 8'h0, 0, 0);
    check("fl_occupancy", occupancy, 0);
    check("fl_valid", out_valid, 0);
    drive(1, 16'h0708, 8'h01, 1, 0);
    step;
    drive(0, 16'h0, 8'h0, 1, 0);
    check("fl_next", out_shares, 16'h0709);
    step;
    drive(1, 16'hAAAA, 8'h0, 0, 0);
    step;
    drive(1, 16'hBBBB, 8'h0, 0, 0);
    step;
    drive(0, 16'h0, 8'h0, 0, 0);
    check("rs_full", occupancy, 2);
    #2 rst_n = 0;
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_occupancy", occupancy, 0);
    check("rs_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    drive(1, 16'h1234, 8'h0F, 1, 0);
    step;
    drive(0, 16'h0, 8'h0, 1, 0);
    check("rs_latency_shares", out_shares, 16'h123B);
    check("rs_latency_valid", out_valid, 1);
    step;
    for (int n = 0; n < 10000; n++) begin
      r_out_ready = $urandom_range(0, 99) < ((n % 200) < 100 ? 30 : 80);
      if (!r_in_valid || r_acc) begin
        r_in_valid = $urandom_range(0, 3) != 0;
        r_in_shares = 12'($urandom);
        r_in_cmpl = 4'($urandom);
      end
      @(negedge clk);
      r_acc = r_in_valid && r_in_ready;
      step;
    end
    r_in_valid = 0;
    r_out_ready = 1;
    repeat (3) step;
    @(negedge clk);
    check("rnd_drain", r_occupancy, rq.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
